// File: rtl/flag_xfer_scheduler_pkg.sv
// Shared definitions for the flag transfer scheduler: FSM encodings, coalesce
// counter geometry and the down-counter sizing helper.
package flag_xfer_scheduler_pkg;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAssert = 2'd1;
    localparam logic [1:0] StGap    = 2'd2;

    localparam int               CoalesceCntW   = 8;
    localparam logic [CoalesceCntW-1:0] CoalesceCntMax = 8'd255;

    // One down-counter serves both phases, so it must hold max(hold, gap) - 1.
    function automatic int cntWidth(input int holdCycles, input int gapCycles);
        int maxCycles;
        maxCycles = (holdCycles > gapCycles) ? holdCycles : gapCycles;
        return (maxCycles > 1) ? $clog2(maxCycles) : 1;
    endfunction

endpackage

// File: rtl/flag_xfer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first pending source at or after the
// pointer wins; returns one-hot grant, binary index and an any-pending flag.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] pending,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_SRC-1:0] grantOh,
    output logic [ID_W-1:0]    grantIdx,
    output logic               grantAny
);

    always_comb begin
        // NOTE: every output gets a default before the search loop so no path leaves a latch.
        grantOh  = '0;
        grantIdx = '0;
        grantAny = 1'b0;
        for (int off = 0; off < NUM_SRC; off++) begin
            int j;
            j = (int'(pointer) + off) % NUM_SRC;
            if (!grantAny && pending[j]) begin
                grantAny   = 1'b1;
                grantOh[j] = 1'b1;
                grantIdx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/flag_xfer_scheduler.sv
// Round-robin serialiser of per-source events onto one flag with guaranteed
// high time and low gap. Optional merged-request statistic: COALESCE_CNT_EN.
module flag_xfer_scheduler
    import flag_xfer_scheduler_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 2,
    parameter int ID_W        = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_SRC-1:0] req_in,
    output logic               flag_out,
    output logic [ID_W-1:0]    flag_id,
    output logic               busy,
    output logic [NUM_SRC-1:0] pending
`ifdef COALESCE_CNT_EN
   ,output logic [CoalesceCntW-1:0] coalesce_cnt
`endif
);

    localparam int CntW = cntWidth(HOLD_CYCLES, GAP_CYCLES);

    logic [1:0]         state;
    logic [CntW-1:0]    cnt;
    logic [ID_W-1:0]    rrPtr;
    logic [NUM_SRC-1:0] grantOh;
    logic [ID_W-1:0]    grantIdx;
    logic               grantAny;
    logic               doGrant;
    logic [NUM_SRC-1:0] grantMask;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) uArb (
        .pending  (pending),
        .pointer  (rrPtr),
        .grantOh  (grantOh),
        .grantIdx (grantIdx),
        .grantAny (grantAny)
    );

    assign doGrant   = (state == StIdle) && enable && grantAny;
    assign grantMask = doGrant ? grantOh : '0;
    assign flag_out  = (state == StAssert);
    assign busy      = (state != StIdle);

    // A request arriving on its own grant edge re-arms the bit as a fresh event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            pending <= (pending & ~grantMask) | req_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            cnt     <= '0;
            flag_id <= '0;
            rrPtr   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (doGrant) begin
                        state   <= StAssert;
                        cnt     <= CntW'(HOLD_CYCLES - 1);
                        flag_id <= grantIdx;
                        rrPtr   <= (int'(grantIdx) == NUM_SRC - 1) ? '0 : grantIdx + 1'b1;
                    end
                end
                StAssert: begin
                    if (cnt == '0) begin
                        state <= StGap;
                        cnt   <= CntW'(GAP_CYCLES - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt == '0) begin
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef COALESCE_CNT_EN
    logic coalesceHit;

    assign coalesceHit = |(req_in & pending & ~grantMask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coalesce_cnt <= '0;
        end else if (coalesceHit && (coalesce_cnt != CoalesceCntMax)) begin
            coalesce_cnt <= coalesce_cnt + 1'b1;
        end
    end
`else
    // Merging still happens through the sticky pending bits; only the statistic is absent.
`endif

endmodule

// File: tb/tb_flag_xfer_scheduler.sv
// Directed bench for flag_xfer_scheduler: expected transfers are queued as
// stimulus is applied and checked by a flag monitor as the DUT emits them.
module tb_flag_xfer_scheduler;

    localparam int NUM_SRC = 4;
    localparam int HOLD    = 3;
    localparam int GAP     = 2;
    localparam int ID_W    = 2;

    typedef struct {
        logic [ID_W-1:0] id;
        int              riseCyc;
    } xfer_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [NUM_SRC-1:0] req_in;
    logic               flag_out;
    logic [ID_W-1:0]    flag_id;
    logic               busy;
    logic [NUM_SRC-1:0] pending;
`ifdef COALESCE_CNT_EN
    logic [7:0]         coalesce_cnt;
`endif

    xfer_t expQ[$];
    int    nCompared = 0;
    int    nMismatch = 0;
    int    cyc = 0;

    flag_xfer_scheduler #(
        .NUM_SRC     (NUM_SRC),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .ID_W        (ID_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .req_in   (req_in),
        .flag_out (flag_out),
        .flag_id  (flag_id),
        .busy     (busy),
        .pending  (pending)
`ifdef COALESCE_CNT_EN
       ,.coalesce_cnt (coalesce_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatch++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitTo(input int target);
        while (cyc < target) tick();
    endtask

    // Drives v for n edges; k is the first edge that samples it.
    task automatic reqHold(input logic [NUM_SRC-1:0] v, input int n, output int k);
        req_in = v;
        tick();
        k = cyc;
        for (int i = 1; i < n; i++) tick();
        req_in = '0;
    endtask

    task automatic expectXfer(input logic [ID_W-1:0] id, input int riseCyc);
        xfer_t x;
        x.id      = id;
        x.riseCyc = riseCyc;
        expQ.push_back(x);
    endtask

    task automatic doReset();
        reset  = 1'b1;
        req_in = '0;
        enable = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    // Flag monitor: pops the scoreboard on each rising edge, checks hold/gap widths.
    initial begin
        logic prevFlag;
        int   highLen;
        int   lowLen;
        bit   sawFall;
        xfer_t x;
        prevFlag = 1'b0;
        highLen  = 0;
        lowLen   = 0;
        sawFall  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                prevFlag = 1'b0;
                highLen  = 0;
                lowLen   = 0;
                sawFall  = 1'b0;
            end else begin
                if (flag_out && !prevFlag) begin
                    if (sawFall) check("gap_len_ok", 32'(lowLen >= GAP), 1);
                    check("rise_expected", 32'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        x = expQ.pop_front();
                        check("xfer_id", 32'(flag_id), 32'(x.id));
                        check("xfer_rise_cyc", cyc, x.riseCyc);
                    end
                    highLen = 1;
                end else if (flag_out) begin
                    highLen++;
                end else if (prevFlag) begin
                    check("hold_len", highLen, HOLD);
                    sawFall = 1'b1;
                    lowLen  = 1;
                end else begin
                    lowLen++;
                end
                prevFlag = flag_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int k2;
        reset  = 1'b1;
        enable = 1'b1;
        req_in = '0;
        #1;
        check("rst_flag_out", 32'(flag_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_flag_id", 32'(flag_id), 0);

        // 1: single request on source 2
        doReset();
        waitTo(9);
        reqHold(4'b0100, 1, k);
        expectXfer(2, k + 1);
        check("t1_pending_latched", 32'(pending), 32'h4);
        waitTo(k + 1);
        check("t1_flag_high", 32'(flag_out), 1);
        check("t1_flag_id", 32'(flag_id), 2);
        check("t1_busy", 32'(busy), 1);
        check("t1_pending_cleared", 32'(pending), 0);
        waitTo(k + 3);
        check("t1_flag_still_high", 32'(flag_out), 1);
        waitTo(k + 4);
        check("t1_flag_low_gap", 32'(flag_out), 0);
        check("t1_busy_gap", 32'(busy), 1);
        waitTo(k + 5);
        check("t1_busy_gap2", 32'(busy), 1);
        waitTo(k + 6);
        check("t1_busy_idle", 32'(busy), 0);
        waitTo(k + 8);
        check("t1_id_kept", 32'(flag_id), 2);

        // 2: fairness over all sources
        doReset();
        reqHold(4'b1111, 1, k);
        for (int i = 0; i < NUM_SRC; i++) expectXfer(ID_W'(i), k + 1 + 6 * i);
        check("t2_pending_all", 32'(pending), 32'hF);
        waitTo(k + 1);
        check("t2_pending_after_first", 32'(pending), 32'hE);
        waitTo(k + 25);
        check("t2_all_done", expQ.size(), 0);
        check("t2_busy_idle", 32'(busy), 0);
        check("t2_pending_empty", 32'(pending), 0);

        // 3: coalescing on source 1 while source 0 is transferring
        doReset();
        reqHold(4'b0001, 1, k);
        expectXfer(0, k + 1);
        expectXfer(1, k + 7);
        waitTo(k + 1);
        for (int i = 0; i < 3; i++) begin
            req_in = 4'b0010;
            tick();
            req_in = '0;
            tick();
        end
        check("t3_pending_granted", 32'(pending), 0);
        waitTo(k + 20);
        check("t3_single_xfer", expQ.size(), 0);
        check("t3_busy_idle", 32'(busy), 0);
`ifdef COALESCE_CNT_EN
        check("t3_coalesce_cnt", 32'(coalesce_cnt), 2);
`endif

        // 4: re-request on the grant edge yields a second transfer
        doReset();
        reqHold(4'b0001, 2, k);
        expectXfer(0, k + 1);
        expectXfer(0, k + 7);
        check("t4_pending_rearmed", 32'(pending), 32'h1);
        waitTo(k + 14);
        check("t4_two_xfers", expQ.size(), 0);
`ifdef COALESCE_CNT_EN
        check("t4_coalesce_cnt", 32'(coalesce_cnt), 0);
`endif

        // 5: enable dropped during ASSERT
        doReset();
        reqHold(4'b0001, 1, k);
        expectXfer(0, k + 1);
        waitTo(k + 1);
        enable = 1'b0;
        req_in = 4'b0010;
        tick();
        req_in = '0;
        waitTo(k + 3);
        check("t5_assert_completes", 32'(flag_out), 1);
        waitTo(k + 12);
        check("t5_no_grant_busy", 32'(busy), 0);
        check("t5_no_grant_flag", 32'(flag_out), 0);
        check("t5_pending_held", 32'(pending), 32'h2);
        enable = 1'b1;
        expectXfer(1, k + 13);
        waitTo(k + 13);
        check("t5_resume_flag", 32'(flag_out), 1);
        check("t5_resume_id", 32'(flag_id), 1);
        waitTo(k + 20);
        check("t5_done", expQ.size(), 0);

        // 6: async reset mid-ASSERT
        doReset();
        reqHold(4'b0110, 1, k);
        expectXfer(1, k + 1);
        waitTo(k + 2);
        check("t6_pending_before", 32'(pending), 32'h4);
        check("t6_flag_before", 32'(flag_out), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_flag", 32'(flag_out), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_pending", 32'(pending), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reqHold(4'b1001, 1, k2);
        expectXfer(0, k2 + 1);
        expectXfer(3, k2 + 7);
        waitTo(k2 + 1);
        check("t6_first_grant", 32'(flag_id), 0);
        waitTo(k2 + 14);
        check("t6_done", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
